// File: rtl/serial_frame_pkg.sv
// Shared state encoding and default framing parameters for serial_frame_ctrl.
// Pure declarations; no logic, no latency, no flow control.
package serial_frame_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_HEADER  = 2'd1,
      ST_PAYLOAD = 2'd2,
      ST_DONE    = 2'd3
   } frame_state_t;

   localparam int         DEF_START_LEN = 4;
   localparam logic [3:0] DEF_START_SEQ = 4'b1101;
   localparam int         DEF_HDR_BITS  = 3;

endpackage

// File: rtl/start_seq_detector.sv
// Sliding-window start pattern matcher; match is combinational with the current bit.
// Zero latency; no backpressure, clr wipes history so no pattern spans frames.
module start_seq_detector #(
   parameter int                   START_LEN = 4,
   parameter logic [START_LEN-1:0] START_SEQ = 4'b1101
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   input  logic serIn,
   output logic match
);

   localparam int             FW       = $clog2(START_LEN + 1);
   localparam logic [FW-1:0]  FILL_MAX = FW'(START_LEN);
   localparam logic [FW-1:0]  FILL_THR = FW'(START_LEN - 1);

   logic [START_LEN-1:0] r_hist;
   logic [FW-1:0]        r_fill;
   logic [START_LEN-1:0] w_window;

   assign w_window = {r_hist[START_LEN-2:0], serIn};
   assign match    = en && (r_fill >= FILL_THR) && (w_window == START_SEQ);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         r_hist <= '0;
         r_fill <= '0;
      end else if (en) begin
         r_hist <= w_window;
         if (r_fill != FILL_MAX)
            r_fill <= r_fill + FW'(1);
      end
   end

endmodule

// File: rtl/serial_frame_ctrl.sv
// Framing FSM: start match -> header capture (shen) -> payload count (cen/valid) -> done.
// iz0/serOut combinational, others registered; no backpressure, serIn consumed every cycle.
module serial_frame_ctrl
   import serial_frame_pkg::*;
#(
   parameter int                   START_LEN = DEF_START_LEN,
   parameter logic [START_LEN-1:0] START_SEQ = DEF_START_SEQ,
   parameter int                   HDR_BITS  = DEF_HDR_BITS
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                serIn,
   output logic                iz0,
   output logic                shen,
   output logic                cen,
   output logic                serOut,
   output logic                valid,
   output logic                done,
   output logic                busy,
   output logic [HDR_BITS-1:0] hdr
);

   localparam int            BW       = $clog2(HDR_BITS + 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(HDR_BITS - 1);

   frame_state_t        r_state;
   logic [HDR_BITS-1:0] r_hdr_sh;
   logic [HDR_BITS-1:0] r_hdr;
   logic [HDR_BITS-1:0] r_pcnt;
   logic [BW-1:0]       r_bitcnt;
   logic                r_shen;
   logic                r_cen;
   logic                r_valid;
   logic                r_done;
   logic                r_busy;

   logic                w_match;
   logic                w_idle;
   logic                w_clr;
   logic [HDR_BITS-1:0] w_hdr_next;

   assign w_idle     = (r_state == ST_IDLE);
   assign w_clr      = (r_state == ST_DONE);
   assign w_hdr_next = {r_hdr_sh[HDR_BITS-2:0], serIn};

   start_seq_detector #(
      .START_LEN (START_LEN),
      .START_SEQ (START_SEQ)
   ) u_det (
      .clk   (clk),
      .rst   (rst),
      .clr   (w_clr),
      .en    (w_idle),
      .serIn (serIn),
      .match (w_match)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_hdr_sh <= '0;
         r_hdr    <= '0;
         r_pcnt   <= '0;
         r_bitcnt <= '0;
         r_shen   <= 1'b0;
         r_cen    <= 1'b0;
         r_valid  <= 1'b0;
         r_done   <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_match) begin
                  r_state  <= ST_HEADER;
                  r_bitcnt <= '0;
                  r_shen   <= 1'b1;
                  r_busy   <= 1'b1;
               end
            end
            ST_HEADER: begin
               r_hdr_sh <= w_hdr_next;
               if (r_bitcnt == LAST_BIT) begin
                  r_hdr    <= w_hdr_next;
                  r_pcnt   <= w_hdr_next;
                  r_bitcnt <= '0;
                  r_state  <= ST_PAYLOAD;
                  r_shen   <= 1'b0;
                  r_cen    <= 1'b1;
                  r_valid  <= 1'b1;
               end else begin
                  r_bitcnt <= r_bitcnt + BW'(1);
               end
            end
            ST_PAYLOAD: begin
               // Stop at zero rather than decrementing, so pcnt never wraps.
               if (r_pcnt == '0) begin
                  r_state <= ST_DONE;
                  r_cen   <= 1'b0;
                  r_valid <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_pcnt <= r_pcnt - 1'b1;
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= ST_IDLE;
               r_shen  <= 1'b0;
               r_cen   <= 1'b0;
               r_valid <= 1'b0;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign iz0    = w_match;
   assign shen   = r_shen;
   assign cen    = r_cen;
   assign valid  = r_valid;
   assign done   = r_done;
   assign busy   = r_busy;
   assign hdr    = r_hdr;
   assign serOut = r_valid & serIn;

endmodule

// File: tb/tb_serial_frame_ctrl.sv
// Directed bench for serial_frame_ctrl: drives serIn at negedge, samples 1ns later.
module tb_serial_frame_ctrl;

   logic       clk;
   logic       rst;
   logic       serIn;
   logic       iz0, shen, cen, serOut, valid, done, busy;
   logic [2:0] hdr;

   int errors = 0;
   int checks = 0;

   // per-run observations
   int n_iz0, n_shen, n_valid, n_done, viol;
   int first_iz0, last_iz0, first_shen, first_valid, first_done;
   logic [7:0] so_bits;

   serial_frame_ctrl dut (
      .clk    (clk),
      .rst    (rst),
      .serIn  (serIn),
      .iz0    (iz0),
      .shen   (shen),
      .cen    (cen),
      .serOut (serOut),
      .valid  (valid),
      .done   (done),
      .busy   (busy),
      .hdr    (hdr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic run_bits(input logic [63:0] bits, input int n);
      n_iz0 = 0; n_shen = 0; n_valid = 0; n_done = 0; viol = 0;
      first_iz0 = -1; last_iz0 = -1; first_shen = -1; first_valid = -1; first_done = -1;
      so_bits = '0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         serIn = bits[n-1-i];
         #1;
         if (iz0) begin
            n_iz0++;
            if (first_iz0 < 0) first_iz0 = i;
            last_iz0 = i;
         end
         if (shen) begin
            n_shen++;
            if (first_shen < 0) first_shen = i;
         end
         if (valid) begin
            n_valid++;
            if (first_valid < 0) first_valid = i;
            so_bits = {so_bits[6:0], serOut};
         end
         if (done) begin
            n_done++;
            if (first_done < 0) first_done = i;
         end
         if ((int'(shen) + int'(cen) + int'(done)) > 1) viol++;
         if (iz0 && busy) viol++;
         if (!valid && serOut) viol++;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; serIn = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0; serIn = 1'b0;
      #1;
      checks++;
      if ({iz0, shen, cen, serOut, valid, done, busy, hdr} !== 10'd0) begin
         errors++;
         $display("FAIL reset_outputs: got %b want 0", {iz0, shen, cen, serOut, valid, done, busy, hdr});
      end
   endtask

   task automatic test_basic;
      run_bits({4'b1101, 3'b010, 3'b101, 1'b0, 2'b00}, 13);
      checks++; if (n_iz0 !== 1) begin errors++; $display("FAIL basic_iz0_count: got %0d want 1", n_iz0); end
      checks++; if (first_iz0 !== 3) begin errors++; $display("FAIL basic_iz0_idx: got %0d want 3", first_iz0); end
      checks++; if (n_shen !== 3 || first_shen !== 4) begin errors++; $display("FAIL basic_shen: got n=%0d idx=%0d want n=3 idx=4", n_shen, first_shen); end
      checks++; if (n_valid !== 3 || first_valid !== 7) begin errors++; $display("FAIL basic_valid: got n=%0d idx=%0d want n=3 idx=7", n_valid, first_valid); end
      checks++; if (so_bits[2:0] !== 3'b101) begin errors++; $display("FAIL basic_serout: got %b want 101", so_bits[2:0]); end
      checks++; if (n_done !== 1 || first_done !== 10) begin errors++; $display("FAIL basic_done: got n=%0d idx=%0d want n=1 idx=10", n_done, first_done); end
      checks++; if (hdr !== 3'b010) begin errors++; $display("FAIL basic_hdr: got %b want 010", hdr); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle: got busy=%b want 0", busy); end
      checks++; if (viol !== 0) begin errors++; $display("FAIL basic_exclusive: got %0d violations want 0", viol); end
   endtask

   task automatic test_boundary;
      run_bits({4'b1101, 3'b000, 1'b1, 1'b0, 2'b00}, 11);
      checks++; if (n_valid !== 1 || first_done !== 8) begin errors++; $display("FAIL hdr000_len: got valid=%0d done_idx=%0d want 1 and 8", n_valid, first_done); end
      checks++; if (hdr !== 3'b000) begin errors++; $display("FAIL hdr000_hdr: got %b want 000", hdr); end
      run_bits({4'b1101, 3'b111, 8'b10110011, 1'b0, 2'b00}, 18);
      checks++; if (n_valid !== 8 || first_done !== 15) begin errors++; $display("FAIL hdr111_len: got valid=%0d done_idx=%0d want 8 and 15", n_valid, first_done); end
      checks++; if (so_bits !== 8'b10110011) begin errors++; $display("FAIL hdr111_serout: got %b want 10110011", so_bits); end
      checks++; if (n_done !== 1 || hdr !== 3'b111 || busy !== 1'b0) begin errors++; $display("FAIL hdr111_end: got done=%0d hdr=%b busy=%b want 1 111 0", n_done, hdr, busy); end
      checks++; if (viol !== 0) begin errors++; $display("FAIL hdr111_exclusive: got %0d violations want 0", viol); end
   endtask

   task automatic test_overlap;
      run_bits({5'b11101, 3'b000, 1'b0, 1'b0, 2'b00}, 12);
      checks++; if (n_iz0 !== 1 || first_iz0 !== 4) begin errors++; $display("FAIL overlap_11101: got n=%0d idx=%0d want n=1 idx=4", n_iz0, first_iz0); end
      run_bits({8'b11001101, 3'b000, 1'b0, 1'b0, 2'b00}, 15);
      checks++; if (n_iz0 !== 1 || first_iz0 !== 7) begin errors++; $display("FAIL false_start: got n=%0d idx=%0d want n=1 idx=7", n_iz0, first_iz0); end
   endtask

   task automatic test_no_cross_frame;
      run_bits({4'b1101, 3'b010, 3'b110, 1'b1, 4'b1010, 4'b1101, 3'b000, 1'b1, 1'b0, 2'b00}, 26);
      checks++; if (n_iz0 !== 2) begin errors++; $display("FAIL cross_iz0_count: got %0d want 2", n_iz0); end
      checks++; if (last_iz0 !== 18) begin errors++; $display("FAIL cross_rematch_idx: got %0d want 18", last_iz0); end
      checks++; if (n_done !== 2 || hdr !== 3'b000) begin errors++; $display("FAIL cross_frames: got done=%0d hdr=%b want 2 000", n_done, hdr); end
   endtask

   task automatic test_back_to_back;
      run_bits({4'b1101, 3'b010, 3'b101, 1'b0, 4'b1101, 2'b11}, 17);
      checks++; if (n_iz0 !== 2 || last_iz0 !== 14) begin errors++; $display("FAIL b2b_iz0: got n=%0d idx=%0d want n=2 idx=14", n_iz0, last_iz0); end
      checks++; if (hdr !== 3'b010 || shen !== 1'b1) begin errors++; $display("FAIL b2b_hdr_hold: got hdr=%b shen=%b want 010 1", hdr, shen); end
      run_bits({1'b1, 8'b01010101, 1'b0, 2'b00}, 12);
      checks++; if (hdr !== 3'b111) begin errors++; $display("FAIL b2b_hdr_update: got %b want 111", hdr); end
      checks++; if (n_valid !== 8 || so_bits !== 8'b01010101 || n_done !== 1) begin errors++; $display("FAIL b2b_payload: got valid=%0d so=%b done=%0d want 8 01010101 1", n_valid, so_bits, n_done); end
   endtask

   task automatic test_mid_reset;
      run_bits({4'b1101, 3'b010, 1'b1}, 8);
      checks++; if (valid !== 1'b1) begin errors++; $display("FAIL midrst_setup: got valid=%b want 1", valid); end
      @(negedge clk); rst = 1'b1;
      @(negedge clk);
      @(negedge clk); rst = 1'b0; serIn = 1'b0;
      #1;
      checks++;
      if ({iz0, shen, cen, serOut, valid, done, busy, hdr} !== 10'd0) begin
         errors++;
         $display("FAIL midrst_outputs: got %b want 0", {iz0, shen, cen, serOut, valid, done, busy, hdr});
      end
      run_bits({3'b101, 3'b000}, 6);
      checks++; if (n_iz0 !== 0 || n_shen !== 0) begin errors++; $display("FAIL midrst_history: got iz0=%0d shen=%0d want 0 0", n_iz0, n_shen); end
      run_bits({4'b1101, 3'b000, 1'b0, 1'b0, 2'b00}, 11);
      checks++; if (n_iz0 !== 1 || first_iz0 !== 3 || n_done !== 1) begin errors++; $display("FAIL midrst_recover: got iz0=%0d idx=%0d done=%0d want 1 3 1", n_iz0, first_iz0, n_done); end
   endtask

   initial begin
      rst = 1'b1;
      serIn = 1'b0;
      test_reset();
      test_basic();
      test_boundary();
      test_overlap();
      test_no_cross_frame();
      test_back_to_back();
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
